// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. It turns the asynchronous line i_rx into bytes.
// A good frame updates the held data bus and pulses o_rx_data_valid for one cycle.
// A stop bit sampled low pulses o_frame_err for one cycle, and the receiver then
// waits for the line to return high before it looks for another start bit.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_data_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             rx_meta;
  logic             rx_s;

  // Two-flop synchronizer; reset to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM: start-bit qualification at mid-bit, then one sample per bit period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      o_rx_data       <= '0;
      o_rx_data_valid <= 1'b0;
      o_frame_err     <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      o_rx_data_valid <= 1'b0;
      o_frame_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            cnt    <= '0;
            o_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              // A short low pulse on the line is treated as a glitch.
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              o_rx_data       <= shreg;
              o_rx_data_valid <= 1'b1;
              state           <= IDLE;
              o_busy          <= 1'b0;
            end else begin
              o_frame_err <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          // Hold off a break until the line returns to idle.
          if (rx_s) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames for uart_rx with a strobe scoreboard.
// The driver pushes the expected strobe kind, data and cycle; a monitor pops on every strobe.
module tb_uart_rx;

  localparam int unsigned C = 16;
  localparam int STROBE_LAT = 3 + (C / 2 - 1) + 9 * C + 1;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] last_good = 8'h00;
  logic       prev_strobe = 1'b0;
  exp_t       sb[$];

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_rx            (rx),
    .o_rx_data       (rx_data),
    .o_rx_data_valid (rx_valid),
    .o_frame_err     (frame_err),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one 8N1 frame starting at a negedge and records the expected strobe.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_t e;
    e.err  = ~stop;
    e.data = stop ? d : last_good;
    e.cyc  = cyc + STROBE_LAT;
    if (stop) last_good = d;
    sb.push_back(e);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_before_start", busy, 0);
    @(negedge clk);
    check("busy_in_start", busy, 1);
    repeat (C - 3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (C) @(negedge clk);
    end
    rx = stop;
    repeat (C) @(negedge clk);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (rx_valid || frame_err)) begin
      check("strobe_exclusive", 32'(rx_valid & frame_err), 0);
      check("strobe_not_consecutive", 32'(prev_strobe), 0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_strobe: valid=%0b err=%0b data=0x%0h, expected no strobe (cycle %0d)",
                 rx_valid, frame_err, rx_data, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_kind_err", 32'(frame_err), 32'(e.err));
        check("strobe_data", 32'(rx_data), 32'(e.data));
        check("strobe_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_strobe = rx_valid | frame_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #1;
    check("reset_data", rx_data, 8'h00);
    check("reset_valid", rx_valid, 0);
    check("reset_err", frame_err, 0);
    check("reset_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single byte, then hold.
    send_frame(8'hA5, 1'b1);
    repeat (50) @(negedge clk);
    check("hold_a5", rx_data, 8'hA5);

    // Glitch rejection.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_busy_high", busy, 1);
    @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("glitch_busy_low", busy, 0);
    check("glitch_data_kept", rx_data, 8'hA5);
    repeat (20) @(negedge clk);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_last_data", rx_data, 8'h3C);

    // Framing error followed by a break, then a good frame.
    send_frame(8'h3C, 1'b0);
    repeat (100) @(negedge clk);
    check("break_busy", busy, 1);
    check("break_data_kept", rx_data, 8'h3C);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("break_released_busy", busy, 0);
    send_frame(8'h12, 1'b1);
    repeat (20) @(negedge clk);

    // Reset during data bit 4 of 0x81.
    rx = 1'b0;
    repeat (C) @(negedge clk);
    rx = 1'b1;
    repeat (C) @(negedge clk);
    rx = 1'b0;
    repeat (3 * C) @(negedge clk);
    repeat (C / 2) @(negedge clk);
    check("midframe_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_data", rx_data, 8'h00);
    check("async_reset_valid", rx_valid, 0);
    check("async_reset_err", frame_err, 0);
    check("async_reset_busy", busy, 0);
    last_good = 8'h00;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);

    // Command byte sequence.
    send_frame(8'h0B, 1'b1);
    send_frame(8'h5A, 1'b1);
    send_frame(8'h0A, 1'b1);
    repeat (40) @(negedge clk);
    check("final_data_held", rx_data, 8'h0A);
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
